pe_traffic_engine: RTL

Processing element attached to router port 5 of each mesh node. It injects single-flit packets into the router and consumes ejected flits. Injection is paced by a programmable gap and throttled by credit-based flow control. Received traffic is checked and counted for NoC bring-up and regression.

---
 rtl/pe_traffic_engine_if.sv | 10 +
 rtl/pe_traffic_engine.sv | 94 +++++++++
 2 files changed

// File: rtl/pe_traffic_engine_if.sv
// pe_traffic_engine_if: flit injection/ejection channel between router port 5 and the PE.
interface pe_traffic_engine_if;
  logic [19:0] datain;
  logic        in_valid;
  logic        ci;
  logic [19:0] dataout;
  logic        out_valid;
  modport master (output datain, in_valid, ci, input dataout, out_valid);
  modport slave (input datain, in_valid, ci, output dataout, out_valid);
endinterface

// File: rtl/pe_traffic_engine.sv
// pe_traffic_engine: paced, credit-throttled single-flit injector with ejection checking and statistics.
module pe_traffic_engine #(
  parameter int         BUF_DEPTH = 4,
  parameter int         GAP_W     = 8,
  parameter int         CNT_W     = 16,
  parameter logic [3:0] LFSR_SEED = 4'b1011
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [3:0]           position,
  input  logic                 enable,
  input  logic [GAP_W-1:0]     gap,
  input  logic [CNT_W-1:0]     num_packets,
  pe_traffic_engine_if.slave   link,
  output logic [CNT_W-1:0]     tx_count,
  output logic [CNT_W-1:0]     rx_count,
  output logic [CNT_W-1:0]     err_count,
  output logic                 credit_err,
  output logic                 done
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, GAP, WAIT, SEND} state_t;
  state_t           state;
  logic [CW-1:0]    credits;
  logic [GAP_W-1:0] cnt;
  logic [11:0]      seq;
  logic [3:0]       lfsr;
  logic [3:0]       dest;
  logic             last;
  assign dest = (lfsr == position) ? position + 4'd1 : lfsr;
  assign last = (num_packets != '0) && (tx_count == num_packets - CNT_W'(1));
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      credits    <= CW'(BUF_DEPTH);
      credit_err <= 1'b0;
    end else if (link.ci && !link.out_valid) begin
      if (credits == CW'(BUF_DEPTH)) credit_err <= 1'b1;
      else credits <= credits + CW'(1);
    end else if (!link.ci && link.out_valid) begin
      credits <= credits - CW'(1);
    end
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      state          <= IDLE;
      cnt            <= '0;
      seq            <= '0;
      lfsr           <= LFSR_SEED;
      link.out_valid <= 1'b0;
      link.dataout   <= '0;
      tx_count       <= '0;
      done           <= 1'b0;
    end else begin
      link.out_valid <= 1'b0;
      case (state)
        IDLE: if (enable && !done) begin
          state <= GAP;
          cnt   <= gap;
        end
        GAP: begin
          if (!enable) state <= IDLE;
          else if (cnt == '0) state <= WAIT;
          else cnt <= cnt - GAP_W'(1);
        end
        WAIT: begin
          if (!enable) state <= IDLE;
          else if (credits != '0) begin
            state          <= SEND;
            link.out_valid <= 1'b1;
            link.dataout   <= {dest, position, seq};
          end
        end
        SEND: begin
          seq      <= seq + 12'd1;
          tx_count <= &tx_count ? tx_count : tx_count + CNT_W'(1);
          lfsr     <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
          if (last) done <= 1'b1;
          if (last || !enable) state <= IDLE;
          else begin
            state <= GAP;
            cnt   <= gap;
          end
        end
      endcase
    end
  always_ff @(posedge clk or negedge RST)
    if (!RST) begin
      rx_count  <= '0;
      err_count <= '0;
    end else if (link.in_valid) begin
      rx_count <= &rx_count ? rx_count : rx_count + CNT_W'(1);
      if (link.datain[19:16] != position)
        err_count <= &err_count ? err_count : err_count + CNT_W'(1);
    end
endmodule
